// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the width of the REQ-state timeout counter.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for a 32-bit data port: byte enables, store-data
// replication, load extraction with sign/zero extension, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    byte_sel   = rdata[{addr, 3'b000} +: 8];
    half_sel   = rdata[{addr[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      end
      SZ_HALF: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
        misaligned = addr[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load or store at a time on a req/ack data
// port, returning extended load data and an error flag to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [1:0]           lat_off;
  logic [1:0]           lat_size;
  logic                 lat_we;
  logic                 lat_unsigned;

  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_unsigned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  // In IDLE the lane logic checks the incoming request; afterwards it works
  // from the latched copy so load extraction ignores live request inputs.
  assign al_off      = (state == IDLE) ? req_addr[1:0] : lat_off;
  assign al_size     = (state == IDLE) ? req_size      : lat_size;
  assign al_unsigned = (state == IDLE) ? req_unsigned  : lat_unsigned;

  lsu_align u_align (
    .addr        (al_off),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata),
    .misaligned  (al_mis)
  );

  // NOTE: all sequential state uses non-blocking assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_off      <= '0;
      lat_size     <= '0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_off      <= req_addr[1:0];
            lat_size     <= req_size;
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            mem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata    <= al_wdata;
            req_ready    <= 1'b0;
            if (al_mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state   <= REQ;
              cnt     <= '0;
              mem_req <= 1'b1;
              mem_we  <= req_we;
              mem_be  <= al_be;
            end
          end
        end
        REQ: begin
          // A late ack still wins over the timeout in the same cycle.
          if (mem_ack || cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= ~mem_ack;
            resp_rdata <= (mem_ack && !lat_we) ? al_rdata : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU sum as the effective address and rs2 as store data, then runs one load or store transaction at a time on a simple req/ack data-memory port.
- Returns aligned, sign- or zero-extended load data, plus an error flag, to writeback.
- Holds off the execute stage through req_ready while a transaction is in flight.

Parameters:
- ADDR_W, 32, address width; must equal the ALU result width.
- DATA_W, 32, data width; fixed at 32, and byte lanes assume 4 bytes.
- TIMEOUT, 16, number of REQ-state cycles without mem_ack before the transaction aborts with error; range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  effective address (ALU result).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  1 = zero-extend load data (LBU/LHU).
- req_wdata  in  DATA_W  store data (rs2); only the low bytes are used for byte/half.
- resp_valid  out  1  one-cycle pulse: transaction complete.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or timeout.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned address, req_addr with bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  memory accepted or completed the access; rdata valid in the same cycle.
- mem_rdata  in  DATA_W  raw memory word.

Behaviour:
- States: IDLE, REQ, RESP. All request fields are latched on acceptance; outputs are driven from the latched copy.
- Reset (async) forces:
  - state = IDLE, timeout counter = 0, all latched fields = 0.
  - req_ready = 1.
  - resp_valid, resp_err, mem_req, mem_we = 0.
  - mem_be = 0, resp_rdata = 0, mem_addr = 0, mem_wdata = 0.
  - A reset mid-transaction aborts silently: mem_req drops at reset assertion and no response is produced.
- IDLE: req_ready = 1. When req_valid is high at an edge, the unit latches the request and checks alignment:
  - Misaligned means half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - Misaligned: go to RESP with err = 1 and no memory access.
  - Aligned: go to REQ with counter = 0.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata are stable for the whole state. req_ready = 0.
  - mem_ack = 1: capture mem_rdata (loads) and go to RESP with err = 0.
  - No ack: counter increments. When counter == TIMEOUT-1 with no ack, go to RESP with err = 1 and rdata = 0.
  - An ack arriving in the same cycle as the timeout takes priority (success).
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. A request is not accepted in this cycle.
- Latency, aligned access with immediate ack:
  - Accept at edge N.
  - mem_req is high during cycle N+1; ack sampled at edge N+1.
  - resp_valid during cycle N+2.
  - Each wait cycle adds one cycle.
- Latency, misaligned access: resp_valid during cycle N+1.
- mem_be:
  - byte: 4'b0001 shifted left by addr[1:0].
  - half: 4'b0011 shifted left by {addr[1],1'b0}.
  - word: 4'b1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction:
  - Select the byte at addr[1:0], or the half at addr[1].
  - Sign-extend from bit 7 or 15 unless req_unsigned = 1.
  - Word loads pass through unchanged.
- Ignored inputs:
  - mem_ack outside REQ.
  - req_valid outside IDLE; the requester must hold it until it sees req_ready.
  - req_unsigned on stores.
  - Latched fields are unaffected by input changes after acceptance.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum {IDLE, REQ, RESP}.
  - Constant TIMEOUT_W = 8.
- Sub-module lsu_align (combinational): inputs addr[1:0], size, unsigned, wdata, rdata; outputs be, wdata_rep, rdata_ext, misaligned. This keeps the FSM free of lane logic and lets it be unit-tested alone.

Test Plan:
- Word load, addr 0x100, mem_rdata 0xDEADBEEF, ack in first REQ cycle:
  - mem_addr = 0x100, be = 1111.
  - resp_valid exactly 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- Signed byte load, addr 0x103, mem_rdata 0x80123456:
  - be = 1000, rdata 0xFFFFFF80.
  - Same with unsigned = 1: rdata 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD:
  - mem_we = 1, mem_addr = 0x200, be = 1100, mem_wdata 0xABCDABCD.
  - resp rdata 0, err 0.
- Misaligned word load at 0x101, and size 11 at 0x100:
  - No mem_req ever asserted.
  - resp_valid 1 cycle after accept, err 1, rdata 0.
- mem_ack withheld, TIMEOUT = 16:
  - mem_req is high for exactly 16 cycles, then resp err 1.
  - Repeat with ack on the 16th cycle: err 0 and data captured.
- Reset asserted in the 3rd REQ cycle:
  - mem_req, resp_valid and mem_be are immediately 0 and req_ready is 1.
  - No resp_valid afterwards; the next request completes normally.
